// File: rtl/tc_pl_bus_txd_shift.sv
//-----------------------------------------------------------------------------
// tc_pl_bus_txd_shift
// Serial data engine for the bus TX path. A 0->1 transition on txd_en pops
// one word from the TX buffer FIFO (1-cycle read latency), shifts it out on
// bus_sclk/bus_sdo (mode-0: sclk idles low, sdo changes on falling sclk),
// then returns a one-cycle txd_cmpt pulse to the TX controller.
//
// Optional build macro:
//   TC_PL_BUS_TXD_PARITY_EN - append one even-parity bit after the data bits.
//
// Parameters:
//   DATA_W    word width in bits (2..32)
//   CLK_DIV   bus_sclk half-period in clk cycles (>= 1)
//   MSB_FIRST 1 = MSB first, 0 = LSB first
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   txd_en        start level from controller; rising edge starts a word
//   txd_cmpt      one-cycle pulse when the word has been shifted out
//   txb_empty     TX FIFO empty flag
//   txb_rd_en     one-cycle FIFO read strobe
//   txb_rd_data   FIFO read data, valid one cycle after txb_rd_en
//   bus_sclk      serial clock, idles low
//   bus_sdo       serial data, idles low
//   txd_busy      high from the start edge through the txd_cmpt cycle
//   txd_underflow sticky: a start was seen with the FIFO empty
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tc_pl_bus_txd_shift #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txd_en,
    output logic              txd_cmpt,
    input  logic              txb_empty,
    output logic              txb_rd_en,
    input  logic [DATA_W-1:0] txb_rd_data,
    output logic              bus_sclk,
    output logic              bus_sdo,
    output logic              txd_busy,
    output logic              txd_underflow
);

`ifdef TC_PL_BUS_TXD_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 1;
`else
    localparam int unsigned NBITS = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef TC_PL_BUS_TXD_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic              txd_en_d;
    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
`ifdef TC_PL_BUS_TXD_PARITY_EN
    logic              par_bit;
`endif

    logic              start_c;
    logic [DATA_W-1:0] sreg_nxt_c;
    logic              sdo_nxt_c;
    logic              sdo_first_c;

    // Rising edge of the controller's enable level
    assign start_c = txd_en & ~txd_en_d;

    // First bit of the incoming word, taken straight from the FIFO data
    assign sdo_first_c = MSB_FIRST ? txb_rd_data[DATA_W-1] : txb_rd_data[0];

    // Shift register advance and the bit that follows the current one
    always_comb begin
        sreg_nxt_c = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        sdo_nxt_c  = MSB_FIRST ? sreg_nxt_c[DATA_W-1] : sreg_nxt_c[0];
`ifdef TC_PL_BUS_TXD_PARITY_EN
        // After the last data bit the parity bit goes out
        if (bit_cnt == LAST_DATA) begin
            sdo_nxt_c = par_bit;
        end
`endif
    end

    // Control FSM, divider, shifter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            txd_en_d      <= 1'b0;
            sreg          <= '0;
            bit_cnt       <= '0;
            div_cnt       <= '0;
            txd_cmpt      <= 1'b0;
            txb_rd_en     <= 1'b0;
            bus_sclk      <= 1'b0;
            bus_sdo       <= 1'b0;
            txd_busy      <= 1'b0;
            txd_underflow <= 1'b0;
`ifdef TC_PL_BUS_TXD_PARITY_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            txd_en_d  <= txd_en;
            txb_rd_en <= 1'b0;
            txd_cmpt  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        txd_busy <= 1'b1;
                        if (txb_empty) begin
                            txd_underflow <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            txb_rd_en <= 1'b1;
                            state     <= S_RD;
                        end
                    end
                end

                // FIFO registers its output during this cycle
                S_RD: begin
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    sreg     <= txb_rd_data;
                    bus_sdo  <= sdo_first_c;
                    bus_sclk <= 1'b0;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
`ifdef TC_PL_BUS_TXD_PARITY_EN
                    par_bit  <= ^txb_rd_data;
`endif
                    state    <= S_SHIFT;
                end

                // Each bit: CLK_DIV cycles sclk low, then CLK_DIV cycles high
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!bus_sclk) begin
                            bus_sclk <= 1'b1;
                        end else begin
                            bus_sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                bus_sdo  <= 1'b0;
                                txd_cmpt <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                                sreg    <= sreg_nxt_c;
                                bus_sdo <= sdo_nxt_c;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                // Entered with txd_cmpt already set from a shifted word;
                // the underflow path arrives with it clear and raises it here.
                S_DONE: begin
                    if (txd_cmpt) begin
                        txd_busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        txd_cmpt <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_pl_bus_txd_shift.sv
`timescale 1ns/1ps

module tb_tc_pl_bus_txd_shift;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CLK_DIV = 4;
`ifdef TC_PL_BUS_TXD_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int WORD_END = 2 + NBITS * 2 * int'(CLK_DIV);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd_en = 1'b0;
    logic txb_empty = 1'b1;
    logic [DATA_W-1:0] txb_rd_data = '0;

    logic txb_rd_en, txd_cmpt, bus_sclk, bus_sdo, txd_busy, txd_underflow;
    logic l_rd_en, l_cmpt, l_sclk, l_sdo, l_busy, l_uf;

    always #5 clk = ~clk;

    tc_pl_bus_txd_shift #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .txd_en(txd_en), .txd_cmpt(txd_cmpt),
        .txb_empty(txb_empty), .txb_rd_en(txb_rd_en), .txb_rd_data(txb_rd_data),
        .bus_sclk(bus_sclk), .bus_sdo(bus_sdo), .txd_busy(txd_busy),
        .txd_underflow(txd_underflow)
    );

    tc_pl_bus_txd_shift #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .txd_en(txd_en), .txd_cmpt(l_cmpt),
        .txb_empty(txb_empty), .txb_rd_en(l_rd_en), .txb_rd_data(txb_rd_data),
        .bus_sclk(l_sclk), .bus_sdo(l_sdo), .txd_busy(l_busy),
        .txd_underflow(l_uf)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO contents seen by the DUT and the reference copy used by the model
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] ref_q[$];

    // Reference model: one transaction described by start edge, word and length
    bit                m_prev_en = 1'b0;
    bit                m_txn = 1'b0;
    bit                m_uf_txn = 1'b0;
    bit                m_uf = 1'b0;
    int                m_t0 = 0;
    int                m_end = 0;
    logic [DATA_W-1:0] m_word = '0;

    function automatic logic bit_of(input logic [DATA_W-1:0] w, input int b, input bit msb);
        if (b >= int'(DATA_W)) return ^w;
        return msb ? w[DATA_W-1-b] : w[b];
    endfunction

    // Expected outputs for the cycle following edge 'cyc'
    task automatic expect_now(input bit msb, output logic e_rd, output logic e_cmpt,
                              output logic e_sclk, output logic e_sdo, output logic e_busy);
        int k, j;
        e_rd = 0; e_cmpt = 0; e_sclk = 0; e_sdo = 0; e_busy = 0;
        k = cyc - m_t0;
        if (m_txn && k >= 0 && k <= m_end) begin
            e_busy = 1;
            if (k == m_end) e_cmpt = 1;
            else if (!m_uf_txn) begin
                if (k == 0) e_rd = 1;
                else if (k >= 2) begin
                    j = k - 2;
                    e_sclk = (j % (2 * int'(CLK_DIV))) >= int'(CLK_DIV);
                    e_sdo  = bit_of(m_word, j / (2 * int'(CLK_DIV)), msb);
                end
            end
        end
    endtask

    // Clock edge bookkeeping: cycle counter, FIFO read port, model start rule
    always @(posedge clk) begin
        bit idle;
        cyc = cyc + 1;
        if (txb_rd_en) begin
            if (fifo_q.size() == 0) begin
                chk("rd_on_empty_fifo", 64'd1, 64'd0);
                txb_rd_data <= DATA_W'($urandom);
            end else begin
                txb_rd_data <= fifo_q.pop_front();
            end
        end else begin
            txb_rd_data <= DATA_W'($urandom);
        end

        if (rst) begin
            m_prev_en = 1'b0;
            m_txn     = 1'b0;
            m_uf      = 1'b0;
        end else begin
            idle = !(m_txn && (cyc - 1 <= m_t0 + m_end));
            if (idle && txd_en && !m_prev_en) begin
                m_txn = 1'b1;
                m_t0  = cyc;
                if (txb_empty) begin
                    m_uf_txn = 1'b1;
                    m_uf     = 1'b1;
                    m_end    = 1;
                end else begin
                    m_uf_txn = 1'b0;
                    m_end    = WORD_END;
                    m_word   = (ref_q.size() > 0) ? ref_q.pop_front() : '0;
                end
            end
            m_prev_en = txd_en;
        end
    end

    // FIFO empty flag follows the queue, updated away from the active edge
    always @(negedge clk) txb_empty = (fifo_q.size() == 0);

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        logic e_rd, e_cmpt, e_sclk, e_sdo, e_busy;
        if (cyc >= 1) begin
            expect_now(1'b1, e_rd, e_cmpt, e_sclk, e_sdo, e_busy);
            chk("m_rd_en", txb_rd_en, e_rd);
            chk("m_cmpt",  txd_cmpt,  e_cmpt);
            chk("m_sclk",  bus_sclk,  e_sclk);
            chk("m_sdo",   bus_sdo,   e_sdo);
            chk("m_busy",  txd_busy,  e_busy);
            chk("m_uf",    txd_underflow, m_uf);
            expect_now(1'b0, e_rd, e_cmpt, e_sclk, e_sdo, e_busy);
            chk("l_rd_en", l_rd_en, e_rd);
            chk("l_cmpt",  l_cmpt,  e_cmpt);
            chk("l_sclk",  l_sclk,  e_sclk);
            chk("l_sdo",   l_sdo,   e_sdo);
            chk("l_busy",  l_busy,  e_busy);
            chk("l_uf",    l_uf,    m_uf);
        end
    end

    // Bits as a receiver sees them on sclk rising edges, plus event counters
    logic [63:0] col_m = '0, col_l = '0;
    int col_n_m = 0, col_n_l = 0;
    logic prev_sclk_m = 1'b0, prev_sclk_l = 1'b0;
    int cmpt_cnt = 0, cmpt_cyc = 0, rd_cnt = 0;

    always @(negedge clk) begin
        if (bus_sclk === 1'b1 && prev_sclk_m === 1'b0) begin
            col_m = {col_m[62:0], bus_sdo};
            col_n_m++;
        end
        if (l_sclk === 1'b1 && prev_sclk_l === 1'b0) begin
            col_l = {col_l[62:0], l_sdo};
            col_n_l++;
        end
        prev_sclk_m = bus_sclk;
        prev_sclk_l = l_sclk;
        if (txd_cmpt === 1'b1) begin
            cmpt_cnt++;
            cmpt_cyc = cyc;
        end
        if (txb_rd_en === 1'b1) rd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_col();
        @(posedge clk);
        col_m = '0; col_l = '0; col_n_m = 0; col_n_l = 0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
    endtask

    // Raise txd_en (caller leaves it low beforehand); e0 is the start edge
    task automatic start_edge(output int e0);
        clear_col();
        @(negedge clk); @(negedge clk);
        txd_en = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic wait_cmpt(input int target, input string name);
        int n = 0;
        while (cmpt_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        chk(name, 64'(cmpt_cnt >= target), 64'd1);
    endtask

    initial begin
        int e0, c0, r0, np;
        logic [DATA_W-1:0] w;

        tick(3);
        rst = 1'b0;
        chk("rst_sclk", bus_sclk, 1'b0);
        chk("rst_sdo", bus_sdo, 1'b0);
        chk("rst_busy", txd_busy, 1'b0);
        chk("rst_uf", txd_underflow, 1'b0);

        // Word A55A, pulsed enable
        @(negedge clk); push_word(16'hA55A);
        start_edge(e0);
        tick(2); txd_en = 1'b0;
        wait_cmpt(1, "t1_cmpt_seen");
        chk("t1_cmpt_offset", 64'(cmpt_cyc - e0), 64'(WORD_END));
`ifdef TC_PL_BUS_TXD_PARITY_EN
        chk("t1_cmpt_lit", 64'(cmpt_cyc - e0), 64'd138);
        chk("t1_bits_msb", col_m, 64'h14AB4);
        chk("t1_bits_lsb", col_l, 64'h0B54A);
`else
        chk("t1_cmpt_lit", 64'(cmpt_cyc - e0), 64'd130);
        chk("t1_bits_msb", col_m, 64'hA55A);
        chk("t1_bits_lsb", col_l, 64'h5AA5);
`endif
        chk("t1_nbits", 64'(col_n_m), 64'(NBITS));
        chk("t1_rd_cnt", 64'(rd_cnt), 64'd1);
        tick(3);
        chk("t1_idle_sclk", bus_sclk, 1'b0);
        chk("t1_idle_sdo", bus_sdo, 1'b0);

        // Word 0001: LSB-first instance sends the single 1 first
        @(negedge clk); push_word(16'h0001);
        start_edge(e0);
        tick(1); txd_en = 1'b0;
        wait_cmpt(2, "t2_cmpt_seen");
`ifdef TC_PL_BUS_TXD_PARITY_EN
        chk("t2_bits_lsb", col_l, 64'h10001);
        chk("t2_bits_msb", col_m, 64'h3);
`else
        chk("t2_bits_lsb", col_l, 64'h8000);
        chk("t2_bits_msb", col_m, 64'h1);
`endif
        tick(3);

        // Underflow: start with empty FIFO
        r0 = rd_cnt;
        start_edge(e0);
        tick(1); txd_en = 1'b0;
        wait_cmpt(3, "t3_cmpt_seen");
        chk("t3_cmpt_offset", 64'(cmpt_cyc - e0), 64'd1);
        chk("t3_no_rd", 64'(rd_cnt - r0), 64'd0);
        chk("t3_uf_set", txd_underflow, 1'b1);
        tick(5);

        // Enable drops at bit 5, re-rises mid-word, held high past txd_cmpt
        @(negedge clk); push_word(16'h0007); push_word(16'h3C96);
        c0 = cmpt_cnt; r0 = rd_cnt;
        start_edge(e0);
        while (cyc < e0 + 2 + 5 * 2 * int'(CLK_DIV)) @(negedge clk);
        txd_en = 1'b0;
        tick(20);
        txd_en = 1'b1;
        wait_cmpt(c0 + 1, "t4_cmpt_seen");
        tick(12);
        chk("t4_one_cmpt", 64'(cmpt_cnt - c0), 64'd1);
        chk("t4_one_rd", 64'(rd_cnt - r0), 64'd1);
        chk("t4_uf_sticky", txd_underflow, 1'b1);
`ifdef TC_PL_BUS_TXD_PARITY_EN
        chk("t6_bits", col_m, 64'hF);
        chk("t6_last_bit", col_m[0], 1'b1);
`else
        chk("t6_bits", col_m, 64'h7);
`endif
        chk("t6_nbits", 64'(col_n_m), 64'(NBITS));
        txd_en = 1'b0;
        start_edge(e0);
        tick(1); txd_en = 1'b0;
        wait_cmpt(c0 + 2, "t4_second_cmpt");
`ifdef TC_PL_BUS_TXD_PARITY_EN
        chk("t4_second_bits", col_m, 64'h792C);
`else
        chk("t4_second_bits", col_m, 64'h3C96);
`endif
        tick(3);

        // Reset mid-word at bit 8, then the next FIFO word goes out cleanly
        @(negedge clk); push_word(16'hF0F0); push_word(16'h1234);
        c0 = cmpt_cnt;
        start_edge(e0);
        tick(1); txd_en = 1'b0;
        while (cyc < e0 + 2 + 8 * 2 * int'(CLK_DIV) + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_sclk", bus_sclk, 1'b0);
        chk("t5_sdo", bus_sdo, 1'b0);
        chk("t5_busy", txd_busy, 1'b0);
        chk("t5_uf_clr", txd_underflow, 1'b0);
        tick(150);
        chk("t5_no_cmpt", 64'(cmpt_cnt - c0), 64'd0);
        start_edge(e0);
        tick(1); txd_en = 1'b0;
        wait_cmpt(c0 + 1, "t5_next_cmpt");
`ifdef TC_PL_BUS_TXD_PARITY_EN
        chk("t5_next_bits", col_m, 64'h2469);
`else
        chk("t5_next_bits", col_m, 64'h1234);
`endif
        tick(3);

        // Random enables, FIFO fills and occasional resets
        for (int it = 0; it < 30; it++) begin
            np = int'($urandom_range(0, 2));
            @(negedge clk);
            for (int p = 0; p < np; p++) begin
                w = DATA_W'($urandom);
                push_word(w);
            end
            tick(2);
            txd_en = 1'b1;
            tick(int'($urandom_range(1, 160)));
            txd_en = 1'b0;
            tick(int'($urandom_range(1, 30)));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
        end
        tick(WORD_END + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
